// File: rtl/serial_to_parallel8.sv
// serial_to_parallel8: serial bit stream to parallel word assembler with a one-word holding buffer.
// Define SER2PAR_PARITY_EN to add an even-parity bit to each frame and a par_err pulse on bad parity.
module serial_to_parallel8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             flush,
  input  logic             p_ready,
  output logic             p_valid,
  output logic [WIDTH-1:0] p_data,
  output logic             ovr,
  input  logic             ovr_clr,
  output logic             par_err
);

`ifdef SER2PAR_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic             r_ovr;

  logic [WIDTH-1:0] w_shift_nx;
  logic [WIDTH-1:0] w_word;
  logic             w_fire;
  logic             w_done;
  logic             w_good;
  logic             w_load;
  logic             w_over;

  always_comb begin
    w_shift_nx = r_shift;
    if (MSB_FIRST)
      w_shift_nx = {r_shift[WIDTH-2:0], s_data};
    else
      w_shift_nx = {s_data, r_shift[WIDTH-1:1]};
  end

  assign w_fire = s_valid & ~flush;
  assign w_done = w_fire & (r_cnt == LAST);

`ifdef SER2PAR_PARITY_EN
  // On the parity bit the shift register already holds the full data word.
  logic w_bad;
  logic r_perr;

  assign w_word = r_shift;
  assign w_bad  = w_done & (^r_shift ^ s_data);
  assign w_good = w_done & ~w_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_perr <= 1'b0;
    else          r_perr <= w_bad;
  end

  assign par_err = r_perr;
`else
  assign w_word  = w_shift_nx;
  assign w_good  = w_done;
  assign par_err = 1'b0;
`endif

  assign w_load = w_good & (~r_valid | p_ready);
  assign w_over = w_good & r_valid & ~p_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (s_valid) begin
      r_shift <= w_shift_nx;
      r_cnt   <= w_done ? '0 : r_cnt + CW'(1);
    end
  end

  // A completion in the accept cycle refills the buffer without a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_word;
    end else if (p_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_ovr <= 1'b0;
    else if (w_over)  r_ovr <= 1'b1;
    else if (ovr_clr) r_ovr <= 1'b0;
  end

  assign p_valid = r_valid;
  assign p_data  = r_data;
  assign ovr     = r_ovr;

endmodule

// File: tb/tb_serial_to_parallel8.sv
// tb_serial_to_parallel8: directed checks of word assembly, handshake, overrun, flush and reset.
// Two instances share inputs: one MSB-first, one LSB-first.
module tb_serial_to_parallel8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_valid;
  logic       s_data;
  logic       flush;
  logic       p_ready;
  logic       ovr_clr;
  logic       m_valid, l_valid;
  logic [7:0] m_data, l_data;
  logic       m_ovr, l_ovr;
  logic       m_perr, l_perr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_to_parallel8 #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data),
    .flush(flush), .p_ready(p_ready), .p_valid(m_valid), .p_data(m_data),
    .ovr(m_ovr), .ovr_clr(ovr_clr), .par_err(m_perr)
  );

  serial_to_parallel8 #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data),
    .flush(flush), .p_ready(p_ready), .p_valid(l_valid), .p_data(l_data),
    .ovr(l_ovr), .ovr_clr(ovr_clr), .par_err(l_perr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
    s_data  = 1'b0;
  endtask

  // w[7] is sent first; p_ready is forced to rdy_last only on the final frame bit.
  task automatic send_word(input logic [7:0] w, input int gap,
                           input logic rdy_last, input logic flip);
    logic sv_rdy;
    sv_rdy = p_ready;
    for (int i = 7; i >= 1; i--) begin
      drive_bit(w[i]);
      for (int g = 0; g < gap; g++) tick();
    end
`ifdef SER2PAR_PARITY_EN
    drive_bit(w[0]);
    p_ready = rdy_last;
    drive_bit((^w) ^ flip);
`else
    p_ready = rdy_last;
    drive_bit(w[0] ^ 1'b0 ^ (flip & 1'b0));
`endif
    p_ready = sv_rdy;
  endtask

  initial begin
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = 1'b0;
    flush   = 1'b0;
    p_ready = 1'b1;
    ovr_clr = 1'b0;
    tick();
    tick();
    check("rst_valid", {m_valid, l_valid}, 2'b00);
    check("rst_data", {m_data, l_data}, 16'h0000);
    check("rst_ovr", {m_ovr, l_ovr}, 2'b00);
    check("rst_perr", {m_perr, l_perr}, 2'b00);
    reset_n = 1'b1;
    tick();

    send_word(8'hA5, 0, 1'b1, 1'b0);
    check("a5_valid", {m_valid, l_valid}, 2'b11);
    check("a5_msb", m_data, 8'hA5);
    check("a5_lsb", l_data, 8'hA5);
    tick();
    check("a5_drop", {m_valid, l_valid}, 2'b00);
    check("a5_hold", m_data, 8'hA5);

    send_word(8'hC0, 3, 1'b1, 1'b0);
    check("gap_valid", {m_valid, l_valid}, 2'b11);
    check("gap_msb", m_data, 8'hC0);
    check("gap_lsb", l_data, 8'h03);
    tick();
    check("gap_drop", m_valid, 1'b0);

    p_ready = 1'b0;
    send_word(8'h3C, 0, 1'b0, 1'b0);
    check("3c_valid", m_valid, 1'b1);
    check("3c_data", {m_data, l_data}, 16'h3C3C);
    check("3c_noovr", m_ovr, 1'b0);
    send_word(8'hFF, 0, 1'b0, 1'b0);
    check("ovr_data", {m_data, l_data}, 16'h3C3C);
    check("ovr_valid", m_valid, 1'b1);
    check("ovr_set", {m_ovr, l_ovr}, 2'b11);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", {m_ovr, l_ovr}, 2'b00);
    check("clr_valid", m_valid, 1'b1);
    p_ready = 1'b1;
    tick();
    check("acc_drop", m_valid, 1'b0);
    check("acc_hold", m_data, 8'h3C);

    p_ready = 1'b0;
    send_word(8'h11, 0, 1'b0, 1'b0);
    check("11_data", {m_data, l_data}, 16'h1188);
    send_word(8'h22, 0, 1'b1, 1'b0);
    check("refill_valid", {m_valid, l_valid}, 2'b11);
    check("refill_data", {m_data, l_data}, 16'h2244);
    check("refill_ovr", m_ovr, 1'b0);
    send_word(8'h55, 0, 1'b0, 1'b0);
    check("ovr2_set", m_ovr, 1'b1);
    check("ovr2_data", m_data, 8'h22);
    ovr_clr = 1'b1;
    send_word(8'h77, 0, 1'b0, 1'b0);
    ovr_clr = 1'b0;
    check("set_wins", {m_ovr, l_ovr}, 2'b11);
    check("set_wins_data", m_data, 8'h22);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    p_ready = 1'b1;
    tick();
    check("clr2", m_ovr, 1'b0);
    check("drop2", m_valid, 1'b0);

    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 1'b1;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    check("flush_nostray", m_valid, 1'b0);
    send_word(8'hC3, 0, 1'b1, 1'b0);
    check("flush_valid", {m_valid, l_valid}, 2'b11);
    check("flush_data", {m_data, l_data}, 16'hC3C3);
    tick();

    p_ready = 1'b0;
    send_word(8'h5A, 0, 1'b0, 1'b0);
    check("prerst_data", m_data, 8'h5A);
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", {m_valid, l_valid}, 2'b00);
    check("arst_data", {m_data, l_data}, 16'h0000);
    #1 reset_n = 1'b1;
    p_ready = 1'b1;
    send_word(8'hC3, 0, 1'b1, 1'b0);
    check("rst_c3_valid", m_valid, 1'b1);
    check("rst_c3_data", {m_data, l_data}, 16'hC3C3);
    tick();
    check("rst_c3_drop", m_valid, 1'b0);

`ifdef SER2PAR_PARITY_EN
    send_word(8'hA5, 0, 1'b1, 1'b0);
    check("par_ok_valid", m_valid, 1'b1);
    check("par_ok_data", m_data, 8'hA5);
    check("par_ok_perr", m_perr, 1'b0);
    tick();
    send_word(8'hA5, 0, 1'b1, 1'b1);
    check("par_bad_perr", {m_perr, l_perr}, 2'b11);
    check("par_bad_valid", m_valid, 1'b0);
    tick();
    check("par_pulse_end", m_perr, 1'b0);
`else
    check("perr_tied", {m_perr, l_perr}, 2'b00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/serial_to_parallel8.md
Name: serial_to_parallel8

Overview:
- Upstream producer for the 8-bit register stage.
- Assembles a serial bit stream into parallel words and presents each word with a valid/ready handshake, so the downstream register captures it.
- Has a one-word holding buffer, a bit counter, overrun detection and a flush.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in p_data[WIDTH-1]; 0 = first bit lands in p_data[0].

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  s_data is valid this cycle.
- s_data  input  1  serial data bit.
- flush  input  1  synchronous; discards the partially assembled word.
- p_ready  input  1  downstream accepts p_data this cycle.
- p_valid  output  1  p_data holds a complete word.
- p_data  output  WIDTH  assembled word.
- ovr  output  1  sticky overrun flag.
- ovr_clr  input  1  synchronous clear of ovr.
- par_err  output  1  one-cycle parity-error pulse (see Optional Feature).

Behaviour:
- Reset (reset_n=0, asynchronous): shift register=0, bit counter=0, p_valid=0, p_data=0, ovr=0, par_err=0.
- Bit counter, width ceil(log2(WIDTH+1)), range 0..FRAME-1.
  - FRAME=WIDTH without the macro, WIDTH+1 with it.
- Each cycle with s_valid=1 and flush=0:
  - s_data is shifted in.
    - MSB_FIRST=1: shift left, new bit enters LSB.
    - MSB_FIRST=0: shift right, new bit enters MSB.
  - The counter increments.
  - s_valid=0 cycles are gaps: shift register and counter hold.
- Completion: s_valid=1 with counter=FRAME-1.
  - The counter wraps to 0.
  - The word is formed from the shift register plus the current bit.
- Holding buffer is loaded at the completion edge if p_valid=0, or if p_valid=1 and p_ready=1 in the same cycle (simultaneous accept and refill).
  - Result: p_valid=1 and p_data=new word after that edge.
  - Latency: last bit sampled at edge N, word visible after edge N.
- Overrun: completion while p_valid=1 and p_ready=0.
  - The new word is dropped.
  - p_data and p_valid are unchanged.
  - ovr is set to 1 at that edge.
- ovr stays at 1 until ovr_clr=1.
  - If ovr_clr and a new overrun occur in the same cycle, set wins: ovr stays 1.
- Handshake:
  - p_valid=1 and p_ready=1 with no completion: p_valid becomes 0 next cycle. p_data holds its last value.
  - p_data never changes while p_valid=1 and p_ready=0.
- flush=1:
  - Counter and shift register go to 0.
  - The s_data bit in that cycle is ignored.
  - The holding buffer, p_valid and ovr are unaffected.
  - flush takes priority over a completion in the same cycle; no word is produced.
- Reset asserted mid-word: the partial word and the held word are lost. After release, assembly restarts at bit 0.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SER2PAR_PARITY_EN.
- Defined:
  - FRAME=WIDTH+1; the final bit of each frame is an even-parity bit.
  - At completion, if XOR(data bits, parity bit)=1:
    - The word is discarded; the holding buffer is not loaded and ovr is not affected.
    - par_err=1 for exactly one cycle after the completion edge.
  - A good-parity word follows the normal completion rules.
- Not defined:
  - FRAME=WIDTH.
  - par_err is tied to 0.
  - No parity logic is synthesised.

Test Plan:
- Reset, then MSB_FIRST=1, p_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> p_valid=1 with p_data=8'hA5 immediately after the 8th edge; p_valid=0 one cycle later.
- MSB_FIRST=0, same bit sequence with s_valid=0 gaps of 3 cycles between bits -> p_data=8'hA5, because bit order reverses on a palindrome-free pattern check using 1,1,0,0,0,0,0,0 -> 8'h03; gaps do not advance the counter.
- p_ready=0, send 8'h3C then 8'hFF -> p_data stays 8'h3C, ovr=1; then ovr_clr=1 -> ovr=0; p_ready=1 -> p_valid drops.
- p_valid=1 holding 8'h11; the 8th bit of 8'h22 arrives in the same cycle as p_ready=1 -> p_valid stays 1, p_data=8'h22, ovr=0.
- Send 5 bits, then either assert flush for one cycle or pulse reset_n low asynchronously mid-cycle -> counter=0; the next 8 bits 8'hC3 yield p_data=8'hC3 with no stray word.
- With SER2PAR_PARITY_EN: frame 8'hA5 + parity 0 -> accepted. Frame 8'hA5 + parity 1 -> par_err pulses for 1 cycle, p_valid stays 0.
